// File: rtl/seg_scan_capture.sv
// Captures a multiplexed 7-segment display bus and turns each digit back into a hex nibble.
// A digit commits only after its pattern repeats on STABLE_COUNT consecutive scans.
module seg_scan_capture #(
    parameter int NUM_DIGITS     = 4,
    parameter int INVERT         = 0,
    parameter int SEL_ACTIVE_LOW = 1,
    parameter int STABLE_COUNT   = 3,
    parameter int TIMEOUT        = 65535
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [6:0]                seg_in,
    input  logic [NUM_DIGITS-1:0]     sel_in,
    output logic [4*NUM_DIGITS-1:0]   hex_out,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic                      update,
    output logic                      scan_err
);
    localparam int            TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [3:0]    CNT_MAX    = 4'(STABLE_COUNT);
    localparam logic [3:0]    CNT_PRE    = 4'(STABLE_COUNT - 1);

    // Inverse of the hex-to-segment decoder; returns {legal, value}.
    function automatic logic [4:0] seg_decode(input logic [6:0] pat);
        case (pat)
            7'h40:   seg_decode = {1'b1, 4'h0};
            7'h79:   seg_decode = {1'b1, 4'h1};
            7'h24:   seg_decode = {1'b1, 4'h2};
            7'h30:   seg_decode = {1'b1, 4'h3};
            7'h19:   seg_decode = {1'b1, 4'h4};
            7'h12:   seg_decode = {1'b1, 4'h5};
            7'h02:   seg_decode = {1'b1, 4'h6};
            7'h78:   seg_decode = {1'b1, 4'h7};
            7'h00:   seg_decode = {1'b1, 4'h8};
            7'h18:   seg_decode = {1'b1, 4'h9};
            7'h08:   seg_decode = {1'b1, 4'hA};
            7'h03:   seg_decode = {1'b1, 4'hB};
            7'h46:   seg_decode = {1'b1, 4'hC};
            7'h21:   seg_decode = {1'b1, 4'hD};
            7'h06:   seg_decode = {1'b1, 4'hE};
            7'h0E:   seg_decode = {1'b1, 4'hF};
            default: seg_decode = {1'b0, 4'h0};
        endcase
    endfunction

    logic [6:0]              seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d, prev_seg_q, prev_seg_d;
    logic [NUM_DIGITS-1:0]   sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d, prev_sel_q, prev_sel_d;
    logic [6:0]              cand_q [NUM_DIGITS];
    logic [6:0]              cand_d [NUM_DIGITS];
    logic [3:0]              cnt_q  [NUM_DIGITS];
    logic [3:0]              cnt_d  [NUM_DIGITS];
    logic [TW-1:0]           timer_q, timer_d;
    logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic                    update_q, update_d, scan_err_q, scan_err_d;
    logic [6:0]              seg_norm_s;
    logic [NUM_DIGITS-1:0]   sel_norm_s;
    logic [3:0]              sel_ones_s;
    logic                    sel_change_s, sample_s;
    logic [4:0]              dec_s;

    // Next-state logic: sampling at the trailing select edge, match counting, commit and timeout.
    always_comb begin
        seg_s1_d = seg_in;
        seg_s2_d = seg_s1_q;
        sel_s1_d = sel_in;
        sel_s2_d = sel_s1_q;
        if (INVERT != 0) seg_norm_s = ~seg_s2_q;
        else             seg_norm_s = seg_s2_q;
        if (SEL_ACTIVE_LOW != 0) sel_norm_s = ~sel_s2_q;
        else                     sel_norm_s = sel_s2_q;
        prev_seg_d = seg_norm_s;
        prev_sel_d = sel_norm_s;

        sel_ones_s = 4'd0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            sel_ones_s = sel_ones_s + {3'b000, prev_sel_q[d]};
        end
        sel_change_s = (sel_norm_s != prev_sel_q);
        sample_s     = sel_change_s && (sel_ones_s == 4'd1);
        scan_err_d   = sel_change_s && (sel_ones_s > 4'd1);
        dec_s        = seg_decode(prev_seg_q);

        cand_d  = cand_q;
        cnt_d   = cnt_q;
        hex_d   = hex_q;
        valid_d = valid_q;
        timer_d = timer_q;

        if (sample_s) begin
            timer_d = '0;
            for (int d = 0; d < NUM_DIGITS; d++) begin
                if (prev_sel_q[d] && (prev_seg_q == cand_q[d])) begin
                    if (cnt_q[d] != CNT_MAX) cnt_d[d] = cnt_q[d] + 4'd1;
                    else                     cnt_d[d] = cnt_q[d];
                    // Commit only on the transition into saturation.
                    if (cnt_q[d] == CNT_PRE) begin
                        if (dec_s[4]) begin
                            hex_d[4*d +: 4] = dec_s[3:0];
                            valid_d[d]      = 1'b1;
                        end else begin
                            valid_d[d]      = 1'b0;
                        end
                    end else begin
                        valid_d[d] = valid_q[d];
                    end
                end else if (prev_sel_q[d]) begin
                    cand_d[d] = prev_seg_q;
                    cnt_d[d]  = 4'd1;
                end else begin
                    cnt_d[d]  = cnt_q[d];
                end
            end
        end else if (timer_q != TIMER_MAX) begin
            timer_d = timer_q + TW'(1);
            if (timer_q == TIMER_LAST) begin
                valid_d = '0;
                for (int d = 0; d < NUM_DIGITS; d++) begin
                    cand_d[d] = 7'h7F;
                    cnt_d[d]  = 4'd0;
                end
            end else begin
                valid_d = valid_q;
            end
        end else begin
            timer_d = timer_q;
        end

        update_d = (hex_d != hex_q) || (valid_d != valid_q);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seg_s1_q   <= 7'h00;
            seg_s2_q   <= 7'h00;
            sel_s1_q   <= '0;
            sel_s2_q   <= '0;
            prev_seg_q <= 7'h00;
            prev_sel_q <= '0;
            for (int d = 0; d < NUM_DIGITS; d++) begin
                cand_q[d] <= 7'h7F;
                cnt_q[d]  <= 4'd0;
            end
            timer_q    <= '0;
            hex_q      <= '0;
            valid_q    <= '0;
            update_q   <= 1'b0;
            scan_err_q <= 1'b0;
        end else begin
            seg_s1_q   <= seg_s1_d;
            seg_s2_q   <= seg_s2_d;
            sel_s1_q   <= sel_s1_d;
            sel_s2_q   <= sel_s2_d;
            prev_seg_q <= prev_seg_d;
            prev_sel_q <= prev_sel_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            hex_q      <= hex_d;
            valid_q    <= valid_d;
            update_q   <= update_d;
            scan_err_q <= scan_err_d;
        end
    end

    assign hex_out     = hex_q;
    assign digit_valid = valid_q;
    assign update      = update_q;
    assign scan_err    = scan_err_q;
endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: a scan-level model pushes expected output states,
// which a monitor pops and compares on every update pulse.
module tb_seg_scan_capture;
    localparam int TO = 100;
    localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        logic [15:0] hex;
        logic [3:0]  valid;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [6:0]  seg_a, seg_b;
    logic [3:0]  sel;
    logic [15:0] hex0, hex1;
    logic [3:0]  valid0, valid1;
    logic        upd0, upd1, err0, err1;

    int   checks = 0;
    int   failures = 0;
    int   upd_cnt = 0;
    int   err_cnt = 0;
    exp_t sb [$];

    logic [6:0]  m_cand [4];
    int          m_cnt  [4];
    logic [15:0] m_hex;
    logic [3:0]  m_valid;

    assign seg_b = ~seg_a;

    seg_scan_capture #(.NUM_DIGITS(4), .INVERT(0), .SEL_ACTIVE_LOW(1), .STABLE_COUNT(3), .TIMEOUT(TO)) dut0 (
        .clock(clock), .reset_n(reset_n), .seg_in(seg_a), .sel_in(sel),
        .hex_out(hex0), .digit_valid(valid0), .update(upd0), .scan_err(err0));

    seg_scan_capture #(.NUM_DIGITS(4), .INVERT(1), .SEL_ACTIVE_LOW(1), .STABLE_COUNT(3), .TIMEOUT(TO)) dut1 (
        .clock(clock), .reset_n(reset_n), .seg_in(seg_b), .sel_in(sel),
        .hex_out(hex1), .digit_valid(valid1), .update(upd1), .scan_err(err1));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 4; d++) begin
            m_cand[d] = 7'h7F;
            m_cnt[d]  = 0;
        end
        m_hex   = 16'h0000;
        m_valid = 4'h0;
        sb.delete();
    endtask

    task automatic model_push(input logic [15:0] h, input logic [3:0] v);
        exp_t e;
        if (h != m_hex || v != m_valid) begin
            e.hex   = h;
            e.valid = v;
            sb.push_back(e);
            m_hex   = h;
            m_valid = v;
        end
    endtask

    task automatic model_sample(input int d, input logic [6:0] p);
        logic [15:0] h;
        logic [3:0]  v;
        logic [3:0]  k4;
        bit          found;
        if (p == m_cand[d]) begin
            if (m_cnt[d] < 3) begin
                m_cnt[d]++;
                if (m_cnt[d] == 3) begin
                    h = m_hex;
                    v = m_valid;
                    found = 1'b0;
                    for (int k = 0; k < 16; k++) begin
                        if (GLYPH[k] == p) begin
                            k4 = k[3:0];
                            found = 1'b1;
                        end
                    end
                    if (found) begin
                        h[4*d +: 4] = k4;
                        v[d] = 1'b1;
                    end else begin
                        v[d] = 1'b0;
                    end
                    model_push(h, v);
                end
            end
        end else begin
            m_cand[d] = p;
            m_cnt[d]  = 1;
        end
    endtask

    task automatic model_timeout();
        for (int d = 0; d < 4; d++) begin
            m_cand[d] = 7'h7F;
            m_cnt[d]  = 0;
        end
        model_push(m_hex, 4'h0);
    endtask

    task automatic idle(input int n);
        sel = 4'hF;
        repeat (n) @(negedge clock);
    endtask

    task automatic window(input int d, input logic [6:0] p);
        seg_a = p;
        sel   = ~(4'b0001 << d);
        repeat (16) @(negedge clock);
        model_sample(d, p);
    endtask

    task automatic scan(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2, input logic [6:0] p3);
        window(0, p0);
        window(1, p1);
        window(2, p2);
        window(3, p3);
        idle(4);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        idle(3);
        reset_n = 1'b1;
        idle(2);
    endtask

    // Scoreboard monitor: every update pulse must match the next expected state.
    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            if (upd0 === 1'b1) begin
                exp_t e;
                upd_cnt++;
                check("sb_nonempty_at_update", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("sb_hex", 32'(hex0), 32'(e.hex));
                    check("sb_valid", 32'(valid0), 32'(e.valid));
                end
            end
            if (err0 === 1'b1) err_cnt++;
        end
    end

    initial begin
        int u;
        int ec;
        seg_a   = 7'h7F;
        sel     = 4'hF;
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        check("reset_hex", 32'(hex0), 32'h0);
        check("reset_valid", 32'(valid0), 32'h0);
        check("reset_update", 32'(upd0), 32'h0);
        check("reset_scan_err", 32'(err0), 32'h0);
        reset_n = 1'b1;
        idle(2);

        u = upd_cnt;
        scan(7'h40, 7'h79, 7'h24, 7'h30);
        scan(7'h40, 7'h79, 7'h24, 7'h30);
        idle(8);
        check("two_scans_not_committed", 32'(valid0), 32'h0);
        scan(7'h40, 7'h79, 7'h24, 7'h30);
        idle(8);
        check("commit_hex", 32'(hex0), 32'h3210);
        check("commit_valid", 32'(valid0), 32'hF);
        check("commit_updates", 32'(upd_cnt - u), 32'd4);
        check("inv_hex", 32'(hex1), 32'h3210);
        check("inv_valid", 32'(valid1), 32'hF);

        u = upd_cnt;
        scan(7'h40, 7'h79, 7'h06, 7'h30);
        scan(7'h40, 7'h79, 7'h06, 7'h30);
        idle(8);
        check("change_hold_hex", 32'(hex0), 32'h3210);
        scan(7'h40, 7'h79, 7'h06, 7'h30);
        idle(8);
        check("change_hex", 32'(hex0), 32'h3E10);
        check("change_valid", 32'(valid0), 32'hF);
        check("change_updates", 32'(upd_cnt - u), 32'd1);

        u = upd_cnt;
        repeat (3) scan(7'h40, 7'h7F, 7'h06, 7'h30);
        idle(8);
        check("blank_hex", 32'(hex0), 32'h3E10);
        check("blank_valid", 32'(valid0), 32'hD);
        check("blank_updates", 32'(upd_cnt - u), 32'd1);
        u = upd_cnt;
        repeat (3) scan(7'h40, 7'h55, 7'h06, 7'h30);
        idle(8);
        check("illegal_hex", 32'(hex0), 32'h3E10);
        check("illegal_valid", 32'(valid0), 32'hD);
        check("illegal_updates", 32'(upd_cnt - u), 32'd0);

        // Asynchronous reset in the middle of a digit window.
        seg_a = 7'h40;
        sel   = 4'hE;
        repeat (8) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("midreset_hex", 32'(hex0), 32'h0);
        check("midreset_valid", 32'(valid0), 32'h0);
        check("midreset_update", 32'(upd0), 32'h0);
        check("midreset_inv_hex", 32'(hex1), 32'h0);
        model_reset();
        @(negedge clock);
        idle(3);
        reset_n = 1'b1;
        idle(2);
        u = upd_cnt;
        scan(7'h40, 7'h79, 7'h24, 7'h30);
        scan(7'h40, 7'h79, 7'h24, 7'h30);
        idle(8);
        check("recommit_pending_valid", 32'(valid0), 32'h0);
        scan(7'h40, 7'h79, 7'h24, 7'h30);
        idle(8);
        check("recommit_hex", 32'(hex0), 32'h3210);
        check("recommit_valid", 32'(valid0), 32'hF);
        check("recommit_updates", 32'(upd_cnt - u), 32'd4);

        do_reset();
        u = upd_cnt;
        for (int i = 0; i < 4; i++) begin
            window(0, (i % 2 == 0) ? 7'h40 : 7'h79);
            idle(4);
        end
        idle(8);
        check("alternate_hex", 32'(hex0), 32'h0);
        check("alternate_valid", 32'(valid0), 32'h0);
        check("alternate_updates", 32'(upd_cnt - u), 32'd0);

        // Two samples of 40, then a double-select window, then the third sample.
        window(0, 7'h40);
        idle(4);
        window(0, 7'h40);
        idle(4);
        ec = err_cnt;
        u  = upd_cnt;
        seg_a = 7'h40;
        sel   = 4'b1100;
        repeat (16) @(negedge clock);
        idle(8);
        check("scan_err_pulses", 32'(err_cnt - ec), 32'd1);
        check("scan_err_no_commit", 32'(valid0), 32'h0);
        window(0, 7'h40);
        idle(8);
        check("post_err_valid", 32'(valid0), 32'h1);
        check("post_err_hex", 32'(hex0), 32'h0);
        check("post_err_updates", 32'(upd_cnt - u), 32'd1);
        check("inv_3f_valid", 32'(valid1), 32'h1);
        check("inv_3f_hex", 32'(hex1), 32'h0);

        u = upd_cnt;
        model_timeout();
        idle(TO + 20);
        check("timeout_valid", 32'(valid0), 32'h0);
        check("timeout_updates", 32'(upd_cnt - u), 32'd1);
        check("timeout_inv_valid", 32'(valid1), 32'h0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
